// File: rtl/sti_dac_pkg.sv
// Shared definitions for the banked serial-transmit / data-arrange path:
// serial length codes, serializer states and word-building helpers.
package sti_dac_pkg;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    // Serial bit count for a length code: 8 * (code + 1)
    function automatic logic [5:0] len_bits(input logic [1:0] len);
        return {({1'b0, len} + 3'd1), 3'b000};
    endfunction

    // Right-aligned serial word; only the low len_bits() bits are meaningful
    function automatic logic [31:0] build_word(input logic [1:0]  len,
                                               input logic        low,
                                               input logic        fill,
                                               input logic [15:0] data);
        logic [31:0] w;
        case (len)
            LEN_8:   w = low ? {24'd0, data[15:8]} : {24'd0, data[7:0]};
            LEN_16:  w = {16'd0, data};
            LEN_24:  w = fill ? {8'd0, data, 8'd0} : {16'd0, data};
            LEN_32:  w = fill ? {data, 16'd0} : {16'd0, data};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sti_dac_banked_serializer.sv
// Word serializer: accepts a 16-bit word under pi_ready back-pressure and shifts
// out 8/16/24/32 bits, MSB- or LSB-first, with no bubble between back-to-back words.
module sti_word_serializer
    import sti_dac_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        msb_i,
    input  logic        low_i,
    input  logic        fill_i,
    input  logic [1:0]  length_i,
    input  logic [15:0] data_i,
    output logic        ready_o,
    output logic        so_data_o,
    output logic        so_valid_o
);

    ser_state_e  state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        msb_q, msb_d;

    logic        last_s;
    logic        ready_s;
    logic        accept_s;
    logic [31:0] word_s;
    logic [5:0]  bits_s;

    assign last_s   = (state_q == SER_SHIFT) && (cnt_q == 6'd1);
    assign ready_s  = (state_q == SER_IDLE) || last_s;
    assign accept_s = load_i && ready_s;
    assign word_s   = build_word(length_i, low_i, fill_i, data_i);
    assign bits_s   = len_bits(length_i);

    // Next-state: load a new word (left-aligned for MSB-first) or shift the current one
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        if (accept_s) begin
            state_d = SER_SHIFT;
            cnt_d   = bits_s;
            msb_d   = msb_i;
            sh_d    = msb_i ? (word_s << (6'd32 - bits_s)) : word_s;
        end else begin
            case (state_q)
                SER_SHIFT: begin
                    if (last_s) begin
                        state_d = SER_IDLE;
                        cnt_d   = 6'd0;
                        sh_d    = 32'd0;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                        sh_d  = msb_q ? (sh_q << 1) : (sh_q >> 1);
                    end
                end
                SER_IDLE: state_d = SER_IDLE;
                default: begin
                    state_d = SER_IDLE;
                    cnt_d   = 6'd0;
                    sh_d    = 32'd0;
                end
            endcase
        end
    end

    // Serializer state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SER_IDLE;
            sh_q    <= 32'd0;
            cnt_q   <= 6'd0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
        end
    end

    assign ready_o    = ready_s;
    assign so_valid_o = (state_q == SER_SHIFT);
    assign so_data_o  = (state_q == SER_SHIFT) && (msb_q ? sh_q[31] : sh_q[0]);

endmodule

// File: rtl/sti_dac_banked.sv
// Serial-transmit / data-arrange top: serializer plus pixel packer writing
// checkerboard-ordered pixels into NBANK odd/even bank pairs.
// Optional feature macro: STI_DAC_ZERO_PAD_EN (zero-pad remaining memory after pi_end).
module sti_dac_banked
    import sti_dac_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned NBANK   = 4,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned ROW_PIX = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              pi_msb_i,
    input  logic              pi_low_i,
    input  logic              pi_fill_i,
    input  logic [1:0]        pi_length_i,
    input  logic [15:0]       pi_data_i,
    input  logic              pi_end_i,
    output logic              pi_ready_o,
    output logic              so_data_o,
    output logic              so_valid_o,
    output logic [NBANK-1:0]  odd_wr_o,
    output logic [NBANK-1:0]  even_wr_o,
    output logic [ADDR_W-1:0] oem_addr_o,
    output logic [PIX_W-1:0]  oem_dataout_o,
    output logic              oem_finish_o
);

    localparam int unsigned BIT_W  = (PIX_W > 2) ? $clog2(PIX_W) : 1;
    localparam int unsigned COL_W  = (ROW_PIX > 2) ? $clog2(ROW_PIX) : 1;
    localparam int unsigned BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PIX_W - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ROW_PIX - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NBANK - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    logic ser_ready_s, so_data_s, so_valid_s;

    sti_word_serializer u_ser (
        .clk_i      (clk_i),
        .rst_i      (reset_i),
        .load_i     (load_i),
        .msb_i      (pi_msb_i),
        .low_i      (pi_low_i),
        .fill_i     (pi_fill_i),
        .length_i   (pi_length_i),
        .data_i     (pi_data_i),
        .ready_o    (ser_ready_s),
        .so_data_o  (so_data_s),
        .so_valid_o (so_valid_s)
    );

    logic [PIX_W-1:0]  pix_sh_q, pix_sh_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              row_par_q, row_par_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              full_q, full_d;
    logic              end_q, end_d;
    logic              finish_q, finish_d;
    logic [NBANK-1:0]  odd_wr_q, odd_wr_d;
    logic [NBANK-1:0]  even_wr_q, even_wr_d;
    logic [ADDR_W-1:0] oem_addr_q, oem_addr_d;
    logic [PIX_W-1:0]  oem_data_q, oem_data_d;

    logic              end_ok_s;
    logic              commit_s;
    logic [PIX_W-1:0]  pixel_s;
    logic              odd_sel_s;
    logic [NBANK-1:0]  bank_oh_s;

    // End of stream only counts with the serializer drained and no new word starting
    assign end_ok_s  = pi_end_i && !end_q && !so_valid_s && !(load_i && ser_ready_s);
    assign odd_sel_s = ~(col_q[0] ^ row_par_q);
    assign bank_oh_s = NBANK'(1) << bank_q;

    // Packer, checkerboard placement, address/bank advance and finish
    always_comb begin
        pix_sh_d   = pix_sh_q;
        bitcnt_d   = bitcnt_q;
        col_d      = col_q;
        row_par_d  = row_par_q;
        addr_d     = addr_q;
        bank_d     = bank_q;
        full_d     = full_q;
        end_d      = end_q;
        finish_d   = finish_q;
        odd_wr_d   = '0;
        even_wr_d  = '0;
        oem_addr_d = oem_addr_q;
        oem_data_d = oem_data_q;
        commit_s   = 1'b0;
        pixel_s    = '0;

        if (so_valid_s && !end_q) begin
            pix_sh_d = {pix_sh_q[PIX_W-2:0], so_data_s};
            if (bitcnt_q == BIT_LAST) begin
                bitcnt_d = '0;
                commit_s = 1'b1;
                pixel_s  = {pix_sh_q[PIX_W-2:0], so_data_s};
            end else begin
                bitcnt_d = bitcnt_q + BIT_W'(1);
            end
        end else if (end_ok_s) begin
            end_d    = 1'b1;
            bitcnt_d = '0;
            pix_sh_d = '0;
        end
`ifdef STI_DAC_ZERO_PAD_EN
        else if (end_q && !full_q) begin
            commit_s = 1'b1;
            pixel_s  = '0;
        end
`endif
        else begin
            pix_sh_d = pix_sh_q;
        end

        if (commit_s && !full_q) begin
            if (odd_sel_s) begin
                odd_wr_d = bank_oh_s;
            end else begin
                even_wr_d = bank_oh_s;
            end
            oem_addr_d = addr_q;
            oem_data_d = pixel_s;
            if (col_q == COL_LAST) begin
                col_d     = '0;
                row_par_d = ~row_par_q;
            end else begin
                col_d = col_q + COL_W'(1);
            end
            // Second pixel of a pair closes the address slot
            if (col_q[0]) begin
                if (addr_q == ADDR_LAST) begin
                    addr_d = '0;
                    if (bank_q == BANK_LAST) begin
                        full_d = 1'b1;
                    end else begin
                        bank_d = bank_q + BANK_W'(1);
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end else begin
                addr_d = addr_q;
            end
        end else begin
            odd_wr_d  = '0;
            even_wr_d = '0;
        end

`ifdef STI_DAC_ZERO_PAD_EN
        finish_d = finish_q | full_q;
`else
        finish_d = finish_q | full_q | end_ok_s;
`endif
    end

    // Packer and write-port registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pix_sh_q   <= '0;
            bitcnt_q   <= '0;
            col_q      <= '0;
            row_par_q  <= 1'b0;
            addr_q     <= '0;
            bank_q     <= '0;
            full_q     <= 1'b0;
            end_q      <= 1'b0;
            finish_q   <= 1'b0;
            odd_wr_q   <= '0;
            even_wr_q  <= '0;
            oem_addr_q <= '0;
            oem_data_q <= '0;
        end else begin
            pix_sh_q   <= pix_sh_d;
            bitcnt_q   <= bitcnt_d;
            col_q      <= col_d;
            row_par_q  <= row_par_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            full_q     <= full_d;
            end_q      <= end_d;
            finish_q   <= finish_d;
            odd_wr_q   <= odd_wr_d;
            even_wr_q  <= even_wr_d;
            oem_addr_q <= oem_addr_d;
            oem_data_q <= oem_data_d;
        end
    end

    assign pi_ready_o    = ser_ready_s;
    assign so_data_o     = so_data_s;
    assign so_valid_o    = so_valid_s;
    assign odd_wr_o      = odd_wr_q;
    assign even_wr_o     = even_wr_q;
    assign oem_addr_o    = oem_addr_q;
    assign oem_dataout_o = oem_data_q;
    assign oem_finish_o  = finish_q;

endmodule

// File: tb/tb_sti_dac_banked.sv
// Directed self-checking bench for sti_dac_banked (default parameters).
module tb_sti_dac_banked;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_fill = 1'b0, pi_end = 1'b0;
    logic [1:0]  pi_length = 2'b00;
    logic [15:0] pi_data = 16'h0000;
    logic        pi_ready, so_data, so_valid, oem_finish;
    logic [3:0]  odd_wr, even_wr;
    logic [4:0]  oem_addr;
    logic [7:0]  oem_dataout;

    sti_dac_banked dut (
        .clk_i(clk), .reset_i(reset), .load_i(load), .pi_msb_i(pi_msb), .pi_low_i(pi_low),
        .pi_fill_i(pi_fill), .pi_length_i(pi_length), .pi_data_i(pi_data), .pi_end_i(pi_end),
        .pi_ready_o(pi_ready), .so_data_o(so_data), .so_valid_o(so_valid),
        .odd_wr_o(odd_wr), .even_wr_o(even_wr), .oem_addr_o(oem_addr),
        .oem_dataout_o(oem_dataout), .oem_finish_o(oem_finish)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int cyc = 0;
    bit ser_bits[$];
    int run_cur = 0, last_run = 0;
    int nwr = 0;
    int wr_bank[1024];
    bit wr_odd[1024];
    int wr_addr[1024];
    int wr_data[1024];
    int multi_hot = 0;
    int last_wr_cyc = 0, fin_rises = 0, fin_cyc = 0, fin_nwr = 0;
    bit fin_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (so_valid) begin
                ser_bits.push_back(so_data);
                run_cur = run_cur + 1;
            end else begin
                if (run_cur != 0) last_run = run_cur;
                run_cur = 0;
            end
            if ((odd_wr | even_wr) != 4'b0000) begin
                if ($countones({odd_wr, even_wr}) != 1) multi_hot = multi_hot + 1;
                if (nwr < 1024) begin
                    wr_odd[nwr] = (odd_wr != 4'b0000);
                    for (int b = 0; b < 4; b++) if (odd_wr[b] | even_wr[b]) wr_bank[nwr] = b;
                    wr_addr[nwr] = int'(oem_addr);
                    wr_data[nwr] = int'(oem_dataout);
                end
                nwr = nwr + 1;
                last_wr_cyc = cyc;
            end
            if (oem_finish && !fin_prev) begin
                fin_rises = fin_rises + 1;
                fin_cyc = cyc;
                fin_nwr = nwr;
            end
            fin_prev = oem_finish;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; pi_end = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic send_word(input logic [1:0] len, input logic msb, input logic low,
                             input logic fill, input logic [15:0] d);
        int w = 0;
        while (!pi_ready && w < 100) begin step(1); w++; end
        if (!pi_ready) begin
            checks++; $display("FAIL send_timeout: pi_ready=%0b required 1", pi_ready);
        end else begin
            pi_length = len; pi_msb = msb; pi_low = low; pi_fill = fill; pi_data = d;
            load = 1'b1;
            step(1);
            load = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++; if (pi_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", pi_ready); else passes++;
        checks++; if (so_valid !== 1'b0 || so_data !== 1'b0) $display("FAIL rst_serial: got %0b%0b want 00", so_valid, so_data); else passes++;
        checks++; if ({odd_wr, even_wr} !== 8'h00) $display("FAIL rst_strobes: got %0h want 0", {odd_wr, even_wr}); else passes++;
        checks++; if (oem_addr !== 5'd0 || oem_dataout !== 8'h00) $display("FAIL rst_addr_data: got %0h/%0h want 0/0", oem_addr, oem_dataout); else passes++;
        checks++; if (oem_finish !== 1'b0) $display("FAIL rst_finish: got %0b want 0", oem_finish); else passes++;
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_ser8();
        int n0 = ser_bits.size();
        logic [7:0] exp = 8'b10100101;
        send_word(2'b00, 1'b1, 1'b1, 1'b0, 16'hA53C);
        checks++; if (so_valid !== 1'b1 || so_data !== 1'b1) $display("FAIL ser8_latency: got v=%0b d=%0b want 1/1", so_valid, so_data); else passes++;
        step(12);
        checks++; if (ser_bits.size() - n0 != 8) $display("FAIL ser8_count: got %0d want 8", ser_bits.size() - n0); else passes++;
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < ser_bits.size()) begin
                checks++; if (ser_bits[n0+i] !== exp[7-i]) $display("FAIL ser8_bit%0d: got %0b want %0b", i, ser_bits[n0+i], exp[7-i]); else passes++;
            end
        end
        checks++; if (last_run != 8) $display("FAIL ser8_run: got %0d want 8", last_run); else passes++;
    endtask

    task automatic test_ser32();
        int n0 = ser_bits.size();
        bit e;
        send_word(2'b11, 1'b0, 1'b0, 1'b0, 16'h8001);
        step(36);
        checks++; if (ser_bits.size() - n0 != 32) $display("FAIL ser32_count: got %0d want 32", ser_bits.size() - n0); else passes++;
        for (int i = 0; i < 32; i++) begin
            e = (i == 0 || i == 15);
            if (n0 + i < ser_bits.size()) begin
                checks++; if (ser_bits[n0+i] !== e) $display("FAIL ser32_bit%0d: got %0b want %0b", i, ser_bits[n0+i], e); else passes++;
            end
        end
        checks++; if (last_run != 32) $display("FAIL ser32_run: got %0d want 32", last_run); else passes++;
    endtask

    task automatic test_back_to_back();
        int n0 = ser_bits.size();
        int ones = 0;
        send_word(2'b01, 1'b1, 1'b0, 1'b0, 16'h0000);
        send_word(2'b10, 1'b1, 1'b0, 1'b1, 16'hFFFF);
        step(45);
        checks++; if (ser_bits.size() - n0 != 40) $display("FAIL b2b_count: got %0d want 40", ser_bits.size() - n0); else passes++;
        checks++; if (last_run != 40) $display("FAIL b2b_run: got %0d want 40", last_run); else passes++;
        for (int i = n0; i < ser_bits.size(); i++) ones += int'(ser_bits[i]);
        checks++; if (ones != 16) $display("FAIL b2b_ones: got %0d want 16", ones); else passes++;
        if (n0 + 39 < ser_bits.size()) begin
            checks++; if (ser_bits[n0+15] !== 1'b0) $display("FAIL b2b_bit15: got %0b want 0", ser_bits[n0+15]); else passes++;
            checks++; if (ser_bits[n0+16] !== 1'b1) $display("FAIL b2b_bit16: got %0b want 1", ser_bits[n0+16]); else passes++;
            checks++; if (ser_bits[n0+39] !== 1'b0) $display("FAIL b2b_bit39: got %0b want 0", ser_bits[n0+39]); else passes++;
        end
    endtask

    task automatic test_ignored_load();
        int n0 = ser_bits.size();
        send_word(2'b00, 1'b1, 1'b0, 1'b0, 16'h00FF);
        checks++; if (pi_ready !== 1'b0) $display("FAIL busy_ready: got %0b want 0", pi_ready); else passes++;
        pi_length = 2'b11; pi_data = 16'h0000; load = 1'b1;
        step(1);
        load = 1'b0;
        step(15);
        checks++; if (ser_bits.size() - n0 != 8) $display("FAIL ignored_count: got %0d want 8", ser_bits.size() - n0); else passes++;
        checks++; if (last_run != 8) $display("FAIL ignored_run: got %0d want 8", last_run); else passes++;
    endtask

    task automatic test_checkerboard();
        int w0;
        bit eo;
        do_reset();
        w0 = nwr;
        for (int j = 0; j < 8; j++) send_word(2'b01, 1'b1, 1'b0, 1'b0, {8'(2*j+1), 8'(2*j+2)});
        step(20);
        checks++; if (nwr - w0 != 16) $display("FAIL cb_count: got %0d want 16", nwr - w0); else passes++;
        for (int i = 0; i < 16 && w0 + i < nwr; i++) begin
            eo = (((i % 8) + (i / 8)) % 2) == 0;
            checks++; if (wr_odd[w0+i] !== eo) $display("FAIL cb_parity%0d: got odd=%0b want %0b", i, wr_odd[w0+i], eo); else passes++;
            checks++; if (wr_addr[w0+i] != i / 2) $display("FAIL cb_addr%0d: got %0d want %0d", i, wr_addr[w0+i], i / 2); else passes++;
            checks++; if (wr_data[w0+i] != i + 1 || wr_bank[w0+i] != 0) $display("FAIL cb_data%0d: got %0h bank %0d want %0h bank 0", i, wr_data[w0+i], wr_bank[w0+i], i + 1); else passes++;
        end
        checks++; if (multi_hot != 0) $display("FAIL cb_onehot: got %0d multi-hot cycles want 0", multi_hot); else passes++;
    endtask

    task automatic test_fill();
        int w0, f0;
        bit eo;
        do_reset();
        w0 = nwr; f0 = fin_rises;
        for (int j = 0; j < 129; j++) send_word(2'b01, 1'b1, 1'b0, 1'b0, {8'(2*j), 8'(2*j+1)});
        step(30);
        checks++; if (nwr - w0 != 256) $display("FAIL fill_count: got %0d want 256", nwr - w0); else passes++;
        for (int i = 0; i < 256 && w0 + i < nwr; i++) begin
            eo = (((i % 8) + (i / 8)) % 2) == 0;
            checks++; if (wr_bank[w0+i] != i / 64 || wr_addr[w0+i] != (i / 2) % 32) $display("FAIL fill_loc%0d: got bank %0d addr %0d want %0d/%0d", i, wr_bank[w0+i], wr_addr[w0+i], i / 64, (i / 2) % 32); else passes++;
            checks++; if (wr_odd[w0+i] !== eo || wr_data[w0+i] != (i % 256)) $display("FAIL fill_pix%0d: got odd=%0b data %0h want %0b/%0h", i, wr_odd[w0+i], wr_data[w0+i], eo, i % 256); else passes++;
        end
        checks++; if (oem_finish !== 1'b1) $display("FAIL fill_finish: got %0b want 1", oem_finish); else passes++;
        checks++; if (fin_rises - f0 != 1) $display("FAIL fill_finish_once: got %0d rises want 1", fin_rises - f0); else passes++;
        checks++; if (fin_nwr - w0 != 256) $display("FAIL fill_finish_when: got %0d writes want 256", fin_nwr - w0); else passes++;
        checks++; if (fin_cyc != last_wr_cyc + 1) $display("FAIL fill_finish_lat: got cycle %0d want %0d", fin_cyc, last_wr_cyc + 1); else passes++;
        checks++; if (multi_hot != 0) $display("FAIL fill_onehot: got %0d want 0", multi_hot); else passes++;
    endtask

    task automatic test_end();
        int w0, f0, w;
        do_reset();
        w0 = nwr; f0 = fin_rises;
        send_word(2'b00, 1'b1, 1'b0, 1'b0, 16'h0011);
        pi_end = 1'b1;
        step(1);
        pi_end = 1'b0;
        send_word(2'b00, 1'b1, 1'b0, 1'b0, 16'h0022);
        send_word(2'b00, 1'b1, 1'b0, 1'b0, 16'h0033);
        step(12);
        checks++; if (nwr - w0 != 3) $display("FAIL end_pre_count: got %0d want 3", nwr - w0); else passes++;
        checks++; if (oem_finish !== 1'b0) $display("FAIL end_busy_ignored: got %0b want 0", oem_finish); else passes++;
        if (nwr - w0 >= 3) begin
            checks++; if (wr_data[w0] != 8'h11 || wr_data[w0+1] != 8'h22 || wr_data[w0+2] != 8'h33) $display("FAIL end_pre_data: got %0h %0h %0h want 11 22 33", wr_data[w0], wr_data[w0+1], wr_data[w0+2]); else passes++;
        end
        pi_end = 1'b1;
        step(1);
        pi_end = 1'b0;
`ifdef STI_DAC_ZERO_PAD_EN
        w = 0;
        while (!oem_finish && w < 400) begin step(1); w++; end
        step(2);
        checks++; if (oem_finish !== 1'b1) $display("FAIL pad_finish: got %0b want 1", oem_finish); else passes++;
        checks++; if (nwr - w0 != 256) $display("FAIL pad_count: got %0d want 256", nwr - w0); else passes++;
        if (nwr - w0 >= 256) begin
            checks++; if (wr_data[w0+3] != 0 || wr_data[w0+255] != 0) $display("FAIL pad_zero: got %0h/%0h want 0/0", wr_data[w0+3], wr_data[w0+255]); else passes++;
            checks++; if (wr_odd[w0+3] !== 1'b0 || wr_addr[w0+3] != 1) $display("FAIL pad_first: got odd=%0b addr %0d want 0/1", wr_odd[w0+3], wr_addr[w0+3]); else passes++;
            checks++; if (wr_bank[w0+255] != 3 || wr_addr[w0+255] != 31) $display("FAIL pad_last: got bank %0d addr %0d want 3/31", wr_bank[w0+255], wr_addr[w0+255]); else passes++;
        end
        checks++; if (fin_cyc != last_wr_cyc + 1) $display("FAIL pad_finish_lat: got %0d want %0d", fin_cyc, last_wr_cyc + 1); else passes++;
`else
        w = 0;
        checks++; if (oem_finish !== 1'b1) $display("FAIL end_finish: got %0b want 1", oem_finish); else passes++;
        step(5);
        checks++; if (nwr - w0 != 3) $display("FAIL end_no_pad: got %0d writes want 3", nwr - w0); else passes++;
        checks++; if (oem_finish !== 1'b1) $display("FAIL end_sticky: got %0b want 1", oem_finish); else passes++;
`endif
        checks++; if (fin_rises - f0 != 1) $display("FAIL end_finish_once: got %0d want 1", fin_rises - f0); else passes++;
    endtask

    task automatic test_reset_mid();
        send_word(2'b01, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        step(3);
        checks++; if (so_valid !== 1'b1) $display("FAIL mid_valid: got %0b want 1", so_valid); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (so_valid !== 1'b0 || so_data !== 1'b0 || pi_ready !== 1'b1) $display("FAIL mid_serial: got v=%0b d=%0b r=%0b want 0/0/1", so_valid, so_data, pi_ready); else passes++;
        checks++; if ({odd_wr, even_wr} !== 8'h00 || oem_addr !== 5'd0 || oem_dataout !== 8'h00) $display("FAIL mid_write: got %0h/%0h/%0h want 0", {odd_wr, even_wr}, oem_addr, oem_dataout); else passes++;
        checks++; if (oem_finish !== 1'b0) $display("FAIL mid_finish: got %0b want 0", oem_finish); else passes++;
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_ser8();
        test_ser32();
        test_back_to_back();
        test_ignored_load();
        test_checkerboard();
        test_fill();
        test_end();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
